// File: rtl/freq_gauge_mc.sv
// freq_gauge_mc: multi-channel frequency meter.
// Each probe clock runs a free-running counter that is sampled at every common gate
// boundary through a toggle req/ack handshake. The ref-domain side turns the count
// delta into Hz, keeps min/max, detects stopped clocks and serves an Avalon-MM slave.
module freq_gauge_mc #(
    parameter int ReferenceClock = 50000000,
    parameter int NumChannels    = 4,
    parameter int GateDivider    = 100,
    parameter int CounterWidth   = 32,
    parameter int TimeoutCycles  = (ReferenceClock / GateDivider) / 2
) (
    input  logic                             ref_clk,
    input  logic                             reset,
    input  logic [NumChannels-1:0]           probe_clk,
    input  logic [$clog2(NumChannels)+1:0]   mm_address,
    input  logic                             mm_read,
    input  logic                             mm_write,
    input  logic [31:0]                      mm_writedata,
    output logic [31:0]                      mm_readdata,
    output logic                             mm_readdatavalid
);

    localparam int GateCycles = ReferenceClock / GateDivider;
    localparam int AW  = $clog2(NumChannels) + 2;
    localparam int CHW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int GW  = (GateCycles > 1) ? $clog2(GateCycles) : 1;
    localparam int TW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [63:0] GateDivW = 64'(GateDivider);

    typedef enum logic [1:0] {ST_SEED, ST_WAIT_SEED, ST_IDLE, ST_WAIT} state_e;

    // Write data carries no information; only the strobe and address matter.
    logic unused_wdata;
    assign unused_wdata = ^mm_writedata;

    // ---------------- gate timer ----------------
    logic [GW-1:0] gate_q, gate_d;
    logic          gate_end;

    // Countdown to the next gate boundary, reloading on zero.
    always_comb begin
        gate_end = (gate_q == '0);
        gate_d   = gate_end ? GW'(GateCycles - 1) : gate_q - GW'(1);
    end

    // Gate countdown register.
    always_ff @(posedge ref_clk) begin
        if (reset) gate_q <= GW'(GateCycles - 1);
        else       gate_q <= gate_d;
    end

    // ---------------- address decode ----------------
    logic [AW-1:0]  a_ch_full;
    logic [CHW-1:0] a_ch;
    logic [1:0]     a_reg;
    logic           a_hit;

    // Split the address into channel and register fields.
    always_comb begin
        a_reg     = mm_address[1:0];
        a_ch_full = mm_address >> 2;
        a_ch      = a_ch_full[CHW-1:0];
        a_hit     = ({{(32-AW){1'b0}}, a_ch_full} < 32'(NumChannels));
    end

    logic [3:0][31:0] rd_regs [NumChannels];

    // ---------------- per-channel logic ----------------
    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        // ref-domain state
        state_e                  state_q, state_d;
        logic                    req_q, req_d;
        logic [CounterWidth-1:0] base_q, base_d;
        logic [31:0]             cur_q, cur_d, min_q, min_d, max_q, max_d;
        logic                    valid_q, valid_d, alive_q, alive_d, sat_q, sat_d;
        logic [TW-1:0]           tmo_q, tmo_d;
        logic                    ack_s1_q, ack_s2_q;

        // probe-domain state; no reset, powers up at zero
        logic [CounterWidth-1:0] cnt_q  = '0;
        logic [CounterWidth-1:0] hold_q = '0;
        logic                    req_s1_q = 1'b0;
        logic                    req_s2_q = 1'b0;
        logic                    ack_q    = 1'b0;

        // Probe counter; capture it into hold when a new request arrives.
        always_ff @(posedge probe_clk[g]) begin
            cnt_q    <= cnt_q + CounterWidth'(1);
            req_s1_q <= req_q;
            req_s2_q <= req_s1_q;
            if (req_s2_q != ack_q) begin
                hold_q <= cnt_q;
                ack_q  <= req_s2_q;
            end
        end

        // Bring the probe acknowledge into the ref domain.
        always_ff @(posedge ref_clk) begin
            ack_s1_q <= ack_q;
            ack_s2_q <= ack_s1_q;
        end

        logic                    hs_done, timeout, clr, waiting, res_sat;
        logic [CounterWidth-1:0] delta;
        logic [63:0]             prod;
        logic [31:0]             res;

        // Handshake status, rate arithmetic and status-clear decode.
        always_comb begin
            hs_done = (ack_s2_q == req_q);
            timeout = (tmo_q >= TW'(TimeoutCycles));
            clr     = mm_write && a_hit && (a_reg == 2'd3) && (a_ch == CHW'(g));
            waiting = (state_q == ST_WAIT) || (state_q == ST_WAIT_SEED);
            delta   = hold_q - base_q;
            prod    = {{(64-CounterWidth){1'b0}}, delta} * GateDivW;
            res_sat = (prod > 64'h0000_0000_FFFF_FFFF);
            res     = res_sat ? '1 : prod[31:0];
        end

        // FSM state register.
        always_ff @(posedge ref_clk) begin
            if (reset) state_q <= ST_SEED;
            else       state_q <= state_d;
        end

        // FSM next-state logic.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                ST_SEED:      if (gate_end) state_d = ST_WAIT_SEED;
                ST_WAIT_SEED: if (hs_done)  state_d = ST_IDLE;
                ST_IDLE:      if (gate_end) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (hs_done)      state_d = ST_IDLE;
                    else if (timeout) state_d = ST_WAIT_SEED;
                end
                default:      state_d = ST_SEED;
            endcase
        end

        // FSM outputs: request toggling, result update, timeout and clear.
        always_comb begin
            req_d   = req_q;
            base_d  = base_q;
            cur_d   = cur_q;
            min_d   = min_q;
            max_d   = max_q;
            valid_d = valid_q;
            alive_d = alive_q;
            sat_d   = sat_q;
            tmo_d   = tmo_q;
            unique case (state_q)
                ST_SEED: if (gate_end) req_d = ~req_q;
                ST_WAIT_SEED: if (hs_done) base_d = hold_q;
                ST_IDLE: begin
                    if (gate_end) begin
                        req_d = ~req_q;
                        tmo_d = '0;
                    end
                end
                ST_WAIT: begin
                    if (hs_done) begin
                        base_d  = hold_q;
                        cur_d   = res;
                        valid_d = 1'b1;
                        alive_d = 1'b1;
                        if (res < min_q) min_d = res;
                        if (res > max_q) max_d = res;
                        if (res_sat)     sat_d = 1'b1;
                    end else if (timeout) begin
                        cur_d   = '0;
                        alive_d = 1'b0;
                        valid_d = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: ;
            endcase
            // Clear overrides a coincident result on min/max/saturated only.
            if (clr) begin
                min_d = '1;
                max_d = '0;
                sat_d = 1'b0;
            end
        end

        // Result and handshake registers.
        always_ff @(posedge ref_clk) begin
            if (reset) begin
                req_q   <= 1'b0;
                base_q  <= '0;
                cur_q   <= '0;
                min_q   <= '1;
                max_q   <= '0;
                valid_q <= 1'b0;
                alive_q <= 1'b0;
                sat_q   <= 1'b0;
                tmo_q   <= '0;
            end else begin
                req_q   <= req_d;
                base_q  <= base_d;
                cur_q   <= cur_d;
                min_q   <= min_d;
                max_q   <= max_d;
                valid_q <= valid_d;
                alive_q <= alive_d;
                sat_q   <= sat_d;
                tmo_q   <= tmo_d;
            end
        end

        assign rd_regs[g] = {{28'b0, sat_q, alive_q, valid_q, waiting}, max_q, min_q, cur_q};
    end

    // ---------------- MM read port ----------------
    logic [31:0] rdata_d;

    // Select the addressed register; unmapped channels read as zero.
    always_comb begin
        rdata_d = a_hit ? rd_regs[a_ch][a_reg] : '0;
    end

    // Registered read data with one-cycle latency.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            mm_readdata      <= '0;
            mm_readdatavalid <= 1'b0;
        end else begin
            mm_readdatavalid <= mm_read;
            if (mm_read) mm_readdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_freq_gauge_mc.sv
// Testbench for freq_gauge_mc: three instances (4-channel main, 8-bit-counter wrap,
// saturation). Reads push expectations into a queue; a monitor pops and compares
// whenever a DUT presents mm_readdatavalid.
`timescale 1ns/1ps
module tb_freq_gauge_mc;

    logic        ref_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] wdata   = 32'hDEAD_BEEF;

    logic [3:0]  m_pclk = '0;
    logic [3:0]  m_addr = '0;
    logic        m_read = 1'b0, m_write = 1'b0, m_rdv;
    logic [31:0] m_rdata;

    logic        w_pclk = 1'b0;
    logic [1:0]  w_addr = '0;
    logic        w_read = 1'b0, w_write = 1'b0, w_rdv;
    logic [31:0] w_rdata;

    logic        s_pclk = 1'b0;
    logic [1:0]  s_addr = '0;
    logic        s_read = 1'b0, s_write = 1'b0, s_rdv;
    logic [31:0] s_rdata;

    real hp [4];
    bit  run [4];
    bit  s_run = 1'b0;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    typedef struct {
        int          dut;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] mask;
        string       tag;
    } exp_t;
    exp_t q [$];

    freq_gauge_mc #(.ReferenceClock(50000), .NumChannels(4), .GateDivider(100), .CounterWidth(32)) u_main (
        .ref_clk(ref_clk), .reset(reset), .probe_clk(m_pclk), .mm_address(m_addr),
        .mm_read(m_read), .mm_write(m_write), .mm_writedata(wdata),
        .mm_readdata(m_rdata), .mm_readdatavalid(m_rdv));

    freq_gauge_mc #(.ReferenceClock(50000), .NumChannels(1), .GateDivider(100), .CounterWidth(8)) u_wrap (
        .ref_clk(ref_clk), .reset(reset), .probe_clk(w_pclk), .mm_address(w_addr),
        .mm_read(w_read), .mm_write(w_write), .mm_writedata(wdata),
        .mm_readdata(w_rdata), .mm_readdatavalid(w_rdv));

    freq_gauge_mc #(.ReferenceClock(1000000000), .NumChannels(1), .GateDivider(1000000), .CounterWidth(32)) u_sat (
        .ref_clk(ref_clk), .reset(reset), .probe_clk(s_pclk), .mm_address(s_addr),
        .mm_read(s_read), .mm_write(s_write), .mm_writedata(wdata),
        .mm_readdata(s_rdata), .mm_readdatavalid(s_rdv));

    always #10 ref_clk = ~ref_clk;   // 50 MHz

    initial begin #2; forever begin wait (run[0]); #(hp[0]) m_pclk[0] = ~m_pclk[0]; end end
    initial begin #2; forever begin wait (run[1]); #(hp[1]) m_pclk[1] = ~m_pclk[1]; end end
    initial begin #2; forever begin wait (run[2]); #(hp[2]) m_pclk[2] = ~m_pclk[2]; end end
    initial begin #2; forever begin wait (run[3]); #(hp[3]) m_pclk[3] = ~m_pclk[3]; end end
    initial begin #7; forever #25 w_pclk = ~w_pclk; end                // 20 MHz
    initial begin forever begin wait (s_run); #1 s_pclk = ~s_pclk; end end  // 500 MHz

    always @(posedge ref_clk) cyc <= reset ? 0 : cyc + 1;

    task automatic mon(input int d, input logic rv, input logic [31:0] data);
        exp_t e;
        if (rv) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_readdatavalid dut%0d got %h expected no response", d, data);
            end else begin
                e = q.pop_front();
                if (e.dut != d || (data & e.mask) < e.lo || (data & e.mask) > e.hi) begin
                    errors++;
                    $display("FAIL %s dut%0d got %h (masked %h) expected %h..%h", e.tag, d,
                             data, data & e.mask, e.lo, e.hi);
                end
            end
        end
    endtask

    always @(negedge ref_clk) begin
        mon(0, m_rdv, m_rdata);
        mon(1, w_rdv, w_rdata);
        mon(2, s_rdv, s_rdata);
    end

    task automatic bus(input int d, input int ch, input int r, input logic rd, input logic wr);
        case (d)
            0: begin m_addr = 4'(ch * 4 + r); m_read = rd; m_write = wr; end
            1: begin w_addr = 2'(r);          w_read = rd; w_write = wr; end
            default: begin s_addr = 2'(r);    s_read = rd; s_write = wr; end
        endcase
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic rdm(input int d, input int ch, input int r, input logic [31:0] mask,
                       input logic [31:0] lo, input logic [31:0] hi, input string tag);
        exp_t e;
        e.dut = d; e.lo = lo; e.hi = hi; e.mask = mask; e.tag = tag;
        q.push_back(e);
        bus(d, ch, r, 1'b1, 1'b0);
        @(negedge ref_clk);
        bus(d, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic rdt(input int d, input int ch, input int r, input logic [31:0] v,
                       input logic [31:0] tol, input string tag);
        rdm(d, ch, r, 32'hFFFF_FFFF, v - tol, v + tol, tag);
    endtask

    task automatic wr(input int d, input int ch, input int r);
        bus(d, ch, r, 1'b0, 1'b1);
        @(negedge ref_clk);
        bus(d, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge ref_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge ref_clk);
        checks++;
        if (m_rdv !== 1'b0 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdv=%b rdata=%h expected rdv=0 rdata=00000000", m_rdv, m_rdata);
        end
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        hp[0] = 20.0; hp[1] = 25.0; hp[2] = 16.667; hp[3] = 12.5;   // 25/20/30/40 MHz
        for (int i = 0; i < 4; i++) run[i] = 1'b1;
        s_run = 1'b1;
        @(negedge ref_clk);
        do_reset();

        // reset state
        wait_until(5);
        rdt(0, 0, 0, 32'h0, 0, "rst_cur0");
        rdt(0, 0, 1, 32'hFFFF_FFFF, 0, "rst_min0");
        rdt(0, 0, 2, 32'h0, 0, "rst_max0");
        rdt(0, 3, 3, 32'h0, 0, "rst_status3");

        // first result after seed gate plus one gate
        wait_until(1200);
        rdt(0, 0, 0, 25000, 100, "cur0_25M");
        rdt(0, 1, 0, 20000, 100, "cur1_20M");
        rdt(0, 2, 0, 30000, 100, "cur2_30M");
        rdt(0, 3, 0, 40000, 100, "cur3_40M");
        rdm(0, 0, 3, 32'h6, 32'h6, 32'h6, "status0_valid");
        rdt(1, 0, 0, 20000, 100, "wrap_cur_g2");

        // status clear on ch1..3, ignored write to ch0 min
        wait_until(1300);
        wr(0, 1, 3); wr(0, 2, 3); wr(0, 3, 3);
        wr(0, 0, 1);
        rdt(0, 0, 1, 25000, 100, "min0_wr_ignored");

        wait_until(1700);
        rdt(0, 1, 1, 20000, 100, "min1_reseed");
        rdt(0, 1, 2, 20000, 100, "max1_reseed");
        rdt(0, 2, 1, 30000, 100, "min2_reseed");
        rdt(0, 2, 2, 30000, 100, "max2_reseed");
        rdt(0, 3, 1, 40000, 100, "min3_reseed");
        rdt(0, 3, 2, 40000, 100, "max3_reseed");
        rdt(1, 0, 0, 20000, 100, "wrap_cur_g3");

        // ch0 to 10 MHz
        wait_until(1720);
        hp[0] = 50.0;

        wait_until(2200);
        rdt(1, 0, 0, 20000, 100, "wrap_cur_g4");
        rdt(2, 0, 0, 32'hFFFF_FFFF, 0, "sat_cur");
        rdt(2, 0, 3, 32'hE, 0, "sat_status");
        s_run = 1'b0;

        wait_until(2300);
        wr(0, 0, 3);

        // ch0 to 30 MHz
        wait_until(2700);
        hp[0] = 16.667;

        wait_until(3700);
        rdt(0, 0, 1, 10000, 100, "min0_vary");
        rdt(0, 0, 2, 30000, 100, "max0_vary");
        rdt(0, 0, 0, 30000, 100, "cur0_30M");
        rdt(1, 0, 0, 20000, 100, "wrap_cur_g7");

        wait_until(3720);
        wr(0, 0, 3);
        rdt(0, 0, 1, 32'hFFFF_FFFF, 0, "min0_cleared");
        rdt(0, 0, 2, 32'h0, 0, "max0_cleared");

        // stop probe1
        wait_until(3740);
        run[1] = 1'b0;
        wait_until(4400);
        rdt(0, 1, 0, 32'h0, 0, "cur1_dead");
        rdt(0, 1, 3, 32'h1, 0, "status1_dead");

        // restart probe1: re-seed gate without a valid result
        wait_until(4700);
        run[1] = 1'b1;
        wait_until(4900);
        rdm(0, 1, 3, 32'h6, 32'h0, 32'h0, "status1_reseed");
        wait_until(5700);
        rdt(0, 1, 0, 20000, 100, "cur1_restart");
        rdm(0, 1, 3, 32'h6, 32'h6, 32'h6, "status1_restart");

        // reset while ch0 waits for its ack
        wait_until(6000);
        rdt(0, 0, 3, 32'h7, 0, "status0_wait");
        do_reset();
        wait_until(5);
        rdt(0, 0, 3, 32'h0, 0, "status0_after_rst");
        rdt(0, 0, 0, 32'h0, 0, "cur0_after_rst");
        wait_until(700);
        rdt(0, 0, 3, 32'h0, 0, "status0_seed_gate");
        wait_until(1200);
        rdt(0, 0, 0, 30000, 100, "cur0_post_rst");
        rdm(0, 0, 3, 32'h6, 32'h6, 32'h6, "status0_post_rst");

        repeat (4) @(negedge ref_clk);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s got no readdatavalid expected a response", e.tag);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
